// File: rtl/gpio_special_gen_if.sv
// dbus peripheral port for gpio_special_gen: request/response structs plus the
// address-decode select, bundled so master and slave sides stay in lockstep.
interface gpio_special_gen_if;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] w_data;
        logic        w_en;
        logic        req;
    } type_dbus2peri_s;

    typedef struct packed {
        logic [31:0] r_data;
        logic        ack;
    } type_peri2dbus_s;

    logic            gpsl_sel_i;
    type_dbus2peri_s dbus2gpio_i;
    type_peri2dbus_s gpio2dbus_o;

    modport master (output gpsl_sel_i, dbus2gpio_i, input gpio2dbus_o);
    modport slave  (input gpsl_sel_i, dbus2gpio_i, output gpio2dbus_o);
endinterface

// File: rtl/gpio_special_gen.sv
// Switch/LED peripheral on the dbus fabric: synchronised switches, atomic LED ops,
// change interrupt. Define GPSL_DEBOUNCE_EN to add the prescaled debounce filter.
module gpio_special_gen #(
    parameter int                  SW_W     = 16,
    parameter int                  LED_W    = 16,
    parameter int                  DB_CNT_W = 20,
    parameter logic [DB_CNT_W-1:0] DB_RST   = 20'd100000
) (
    input  logic                clk,
    input  logic                rst_n,
    gpio_special_gen_if.slave   bus,
    input  logic [SW_W-1:0]     gp_switch_i,
    output logic [LED_W-1:0]    gp_led_o,
    output logic                gpsl_irq_o
);
    localparam logic [7:0] A_SW   = 8'h00;
    localparam logic [7:0] A_LED  = 8'h04;
    localparam logic [7:0] A_SET  = 8'h08;
    localparam logic [7:0] A_CLR  = 8'h0C;
    localparam logic [7:0] A_TGL  = 8'h10;
    localparam logic [7:0] A_IEN  = 8'h14;
    localparam logic [7:0] A_IST  = 8'h18;
    localparam logic [7:0] A_DBL  = 8'h1C;

    logic             r_ack;
    logic [31:0]      r_rdata;
    logic [SW_W-1:0]  r_sync1, r_sync2;
    logic [SW_W-1:0]  r_sw;
    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_irq_en, r_irq_stat;

    logic             w_rd_req, w_wr_req, w_acc, w_wr;
    logic [7:0]       w_addr;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    logic [SW_W-1:0]  w_sw_next;
    logic [SW_W-1:0]  w_stat_clr;
    logic             w_unused;

    assign w_addr   = bus.dbus2gpio_i.addr[7:0];
    assign w_wdata  = bus.dbus2gpio_i.w_data;
    assign w_rd_req = bus.dbus2gpio_i.req & ~bus.dbus2gpio_i.w_en & bus.gpsl_sel_i;
    assign w_wr_req = bus.dbus2gpio_i.req &  bus.dbus2gpio_i.w_en & bus.gpsl_sel_i;
    // A held request is refused while ack is up, giving the every-other-cycle ack.
    assign w_acc    = (w_rd_req | w_wr_req) & ~r_ack;
    assign w_wr     = w_wr_req & ~r_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gp_switch_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPSL_DEBOUNCE_EN
    logic [DB_CNT_W-1:0] r_cnt, r_db_limit;
    logic [SW_W-1:0]     r_samp;
    logic                w_tick;
    logic [SW_W-1:0]     w_agree;

    assign w_tick    = (r_cnt >= r_db_limit);
    assign w_agree   = ~(r_samp ^ r_sync2);
    // Only bits whose last two tick samples match are allowed through.
    assign w_sw_next = w_tick ? ((w_agree & r_samp) | (~w_agree & r_sw)) : r_sw;
    assign w_unused  = ^{bus.dbus2gpio_i.addr, w_wdata};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_db_limit <= DB_RST;
            r_samp     <= '0;
        end else begin
            if (w_wr && w_addr == A_DBL) begin
                r_db_limit <= w_wdata[DB_CNT_W-1:0];
                r_cnt      <= '0;
            end else if (w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + DB_CNT_W'(1);
            end
            if (w_tick) r_samp <= r_sync2;
        end
    end
`else
    assign w_sw_next = r_sync2;
    assign w_unused  = ^{bus.dbus2gpio_i.addr, w_wdata, DB_RST};
`endif

    assign w_stat_clr = (w_wr && w_addr == A_IST) ? w_wdata[SW_W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw       <= '0;
            r_led      <= '0;
            r_irq_en   <= '0;
            r_irq_stat <= '0;
        end else begin
            r_sw       <= w_sw_next;
            // Clear first, then OR in fresh edges so a coincident change is kept.
            r_irq_stat <= (r_irq_stat & ~w_stat_clr) | (w_sw_next ^ r_sw);
            if (w_wr) begin
                case (w_addr)
                    A_LED:   r_led    <= w_wdata[LED_W-1:0];
                    A_SET:   r_led    <= r_led |  w_wdata[LED_W-1:0];
                    A_CLR:   r_led    <= r_led & ~w_wdata[LED_W-1:0];
                    A_TGL:   r_led    <= r_led ^  w_wdata[LED_W-1:0];
                    A_IEN:   r_irq_en <= w_wdata[SW_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            A_SW:    w_rdata = 32'(r_sw);
            A_LED:   w_rdata = 32'(r_led);
            A_IEN:   w_rdata = 32'(r_irq_en);
            A_IST:   w_rdata = 32'(r_irq_stat);
`ifdef GPSL_DEBOUNCE_EN
            A_DBL:   w_rdata = 32'(r_db_limit);
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= (w_acc & w_rd_req) ? w_rdata : '0;
        end
    end

    assign bus.gpio2dbus_o = {r_rdata, r_ack};
    assign gp_led_o        = r_led;
    assign gpsl_irq_o      = |(r_irq_stat & r_irq_en);
endmodule

// File: tb/tb_gpio_special_gen.sv
// Directed bench for gpio_special_gen: read data checked by a scoreboard monitor,
// LED/IRQ/ack levels checked inline. Works with or without GPSL_DEBOUNCE_EN.
module tb_gpio_special_gen;
    localparam int SW_W  = 16;
    localparam int LED_W = 16;
`ifdef GPSL_DEBOUNCE_EN
    localparam int          LAT    = 4;
    localparam logic [31:0] DB_EXP = 32'd100000;
`else
    localparam int          LAT    = 3;
    localparam logic [31:0] DB_EXP = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [SW_W-1:0]  sw = '0;
    logic [LED_W-1:0] led;
    logic             irq;
    int               errs = 0;
    int               checks = 0;
    logic [31:0]      expq[$];

    gpio_special_gen_if bus();

    gpio_special_gen #(.SW_W(SW_W), .LED_W(LED_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .gp_switch_i(sw), .gp_led_o(led), .gpsl_irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected r_data.
    always @(negedge clk) begin
        if (rst_n && bus.gpio2dbus_o.ack === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL spurious_ack: got ack with r_data %h expected no ack", bus.gpio2dbus_o.r_data);
            end else begin
                chk("r_data", bus.gpio2dbus_o.r_data, expq.pop_front());
            end
        end
    end

    // Called at a negedge; request is accepted on the next posedge.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [31:0] exp);
        int n;
        bus.gpsl_sel_i         = 1'b1;
        bus.dbus2gpio_i.addr   = a;
        bus.dbus2gpio_i.w_data = d;
        bus.dbus2gpio_i.w_en   = we;
        bus.dbus2gpio_i.req    = 1'b1;
        expq.push_back(we ? 32'h0 : exp);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gpio2dbus_o.ack !== 1'b1 && n < 4);
        chk("ack_latency", 32'(n), 32'd1);
        bus.dbus2gpio_i.req  = 1'b0;
        bus.dbus2gpio_i.w_en = 1'b0;
        bus.gpsl_sel_i       = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        xfer(a, d, 1'b1, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        xfer(a, 32'h0, 1'b0, exp);
    endtask

    initial begin
        bus.gpsl_sel_i  = 1'b0;
        bus.dbus2gpio_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_ack", 32'(bus.gpio2dbus_o.ack), 32'h0);
        chk("rst_rdata", bus.gpio2dbus_o.r_data, 32'h0);
        @(negedge clk);

        for (int a = 0; a < 32; a += 4)
            rd(32'(a), (a == 32'h1C) ? DB_EXP : 32'h0);

        wr(32'h04, 32'h00F0);
        wr(32'h08, 32'h000F);
        wr(32'h0C, 32'h0030);
        chk("led_after_clr", 32'(led), 32'h00CF);
        wr(32'h10, 32'h8001);
        chk("led_after_tgl", 32'(led), 32'h80CE);
        rd(32'h04, 32'h80CE);
        rd(32'h08, 32'h0);

        rd(32'h40, 32'h0);
        wr(32'h44, 32'hFFFF);
        chk("led_unmapped_wr", 32'(led), 32'h80CE);

        bus.gpsl_sel_i         = 1'b0;
        bus.dbus2gpio_i.addr   = 32'h04;
        bus.dbus2gpio_i.w_data = 32'hFFFF;
        bus.dbus2gpio_i.w_en   = 1'b1;
        bus.dbus2gpio_i.req    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("nosel_ack", 32'(bus.gpio2dbus_o.ack), 32'h0);
        end
        bus.dbus2gpio_i.req  = 1'b0;
        bus.dbus2gpio_i.w_en = 1'b0;
        @(negedge clk);
        rd(32'h04, 32'h80CE);

        // Held read: ack toggles 0,1,0,1 across four samples.
        expq.push_back(32'h80CE);
        expq.push_back(32'h80CE);
        bus.gpsl_sel_i       = 1'b1;
        bus.dbus2gpio_i.addr = 32'h04;
        bus.dbus2gpio_i.req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("held_ack", 32'(bus.gpio2dbus_o.ack), 32'(i % 2));
        end
        bus.dbus2gpio_i.req = 1'b0;
        bus.gpsl_sel_i      = 1'b0;
        @(negedge clk);

`ifdef GPSL_DEBOUNCE_EN
        wr(32'h1C, 32'd3);
        rd(32'h1C, 32'd3);
        sw = 16'h0004;
        repeat (2) @(negedge clk);
        sw = 16'h0000;
        repeat (20) @(negedge clk);
        rd(32'h00, 32'h0);
        rd(32'h18, 32'h0);
        sw = 16'h0004;
        repeat (12) @(negedge clk);
        rd(32'h00, 32'h0004);
        rd(32'h18, 32'h0004);
        chk("irq_masked", 32'(irq), 32'h0);
        sw = 16'h0000;
        repeat (20) @(negedge clk);
        rd(32'h00, 32'h0);
        wr(32'h1C, 32'd0);
`else
        wr(32'h1C, 32'd5);
`endif
        rd(32'h1C, 32'h0);
        wr(32'h18, 32'hFFFF);
        rd(32'h18, 32'h0);

        // Latency: not yet visible after LAT-1 edges, visible after LAT.
        sw = 16'h0020;
        repeat (LAT - 1) @(negedge clk);
        rd(32'h00, 32'h0000);
        repeat (10) @(negedge clk);
        sw = 16'h0060;
        repeat (LAT) @(negedge clk);
        rd(32'h00, 32'h0060);
        sw = 16'h0000;
        repeat (10) @(negedge clk);
        rd(32'h00, 32'h0);
        wr(32'h18, 32'hFFFF);
        rd(32'h18, 32'h0);

        wr(32'h14, 32'h0004);
        rd(32'h14, 32'h0004);
        chk("irq_idle", 32'(irq), 32'h0);
        sw = 16'h0004;
        repeat (10) @(negedge clk);
        chk("irq_rise", 32'(irq), 32'h1);
        rd(32'h18, 32'h0004);
        wr(32'h18, 32'h0004);
        chk("irq_w1c", 32'(irq), 32'h0);
        rd(32'h18, 32'h0);

        // Falling edge lands on the same posedge that accepts the W1C.
        sw = 16'h0000;
        repeat (LAT - 1) @(negedge clk);
        wr(32'h18, 32'h0004);
        rd(32'h18, 32'h0004);
        chk("irq_set_wins", 32'(irq), 32'h1);
        rd(32'h00, 32'h0);
        wr(32'h14, 32'h0);
        chk("irq_en_off", 32'(irq), 32'h0);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/gpio_special_gen.md
Name: gpio_special_gen

Overview:
- Parametrised successor of the special-purpose switch/LED peripheral on the dbus peripheral fabric.
- Switch and LED widths are configurable.
- Switch inputs get a 2-flop synchroniser and a programmable debounce.
- LEDs support atomic set/clear/toggle writes.
- Debounced switch changes raise a maskable, level interrupt to the PLIC.

Parameters:
- SW_W, 16, number of switch inputs (1..32)
- LED_W, 16, number of LED outputs (1..32)
- DB_CNT_W, 20, width of the debounce prescaler counter
- DB_RST, 20'd100000, reset value of DB_LIMIT (sample period in clk cycles)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- gpsl_sel_i  in  1  address-decode select for this peripheral
- dbus2gpio_i  in  type_dbus2peri_s  bus request (addr, w_data, w_en, req)
- gpio2dbus_o  out  type_peri2dbus_s  bus response (r_data, ack)
- gp_switch_i  in  SW_W  asynchronous switch inputs
- gp_led_o  out  LED_W  LED drive, equals LED_DATA
- gpsl_irq_o  out  1  interrupt, |(IRQ_STAT & IRQ_EN)

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. All flops clear on reset; DB_LIMIT loads DB_RST. Outputs after reset: gp_led_o=0, gpsl_irq_o=0, ack=0, r_data=0.
- Register map (addr[7:0], 32-bit, unused bits read 0):
  - 0x00 SW_DATA: RO, debounced switches.
  - 0x04 LED_DATA: RW.
  - 0x08 LED_SET: WO, LED_DATA |= wdata.
  - 0x0C LED_CLR: WO, LED_DATA &= ~wdata.
  - 0x10 LED_TGL: WO, LED_DATA ^= wdata.
  - 0x14 IRQ_EN: RW, SW_W bits.
  - 0x18 IRQ_STAT: RW1C.
  - 0x1C DB_LIMIT: RW, DB_CNT_W bits.
  - WO registers read 0. Unmapped addresses: reads return 0, writes are ignored; both still ack.
- Handshake:
  - rd_req = req & ~w_en & gpsl_sel_i; wr_req = req & w_en & gpsl_sel_i.
  - When (rd_req|wr_req) & ~ack: ack=1 in the next cycle for exactly one cycle. r_data is registered in that same cycle (0 for writes).
  - The write side effect takes place on the accepting edge.
  - A request held high acks every other cycle; the master must drop req on ack.
- Synchroniser: 2 flops per switch bit. sync is 0 after reset.
- Debounce (shared prescaler):
  - cnt increments every cycle. When cnt >= DB_LIMIT, tick=1 and cnt<=0.
  - On each tick: samp<=sync. Bit i of SW_DATA <= samp[i] only when samp[i]==sync[i], i.e. two consecutive tick samples agree.
  - DB_LIMIT=0 gives a tick every cycle: minimum latency of 4 cycles from input to SW_DATA.
  - Writing DB_LIMIT also clears cnt.
- Interrupt:
  - chg = SW_DATA_next ^ SW_DATA (both edges). IRQ_STAT |= chg each cycle.
  - A W1C write in the same cycle as a new change on the same bit leaves the bit set (set wins).
  - gpsl_irq_o is combinational from registered state, 0 when IRQ_EN=0.
- Width rules: LED writes use wdata[LED_W-1:0]. IRQ_EN/IRQ_STAT use wdata[SW_W-1:0].
- Mid-operation reset: any pending ack is dropped and the transaction is lost; the master must retry.

Optional Feature:
- Macro: GPSL_DEBOUNCE_EN.
- Defined: prescaler/debounce logic as above.
- Undefined:
  - SW_DATA <= sync each cycle (3-cycle latency from input).
  - DB_LIMIT reads 0 and writes to it are ignored (still acked).
  - No prescaler flops are instantiated.

Test Plan:
- Reset, then read 0x00..0x1C -> all 0 except DB_LIMIT=DB_RST; gp_led_o=0; ack exactly one cycle after req.
- Write LED_DATA=0x00F0, LED_SET 0x000F, LED_CLR 0x0030, LED_TGL 0x8001 -> gp_led_o=0x00CF then 0x80CE; readback of LED_DATA matches.
- DB_LIMIT=3; glitch switch[2] high for 2 cycles -> SW_DATA unchanged, no IRQ. Hold high for 12 cycles -> SW_DATA[2]=1.
- IRQ_EN=0x0004; switch[2] rises -> IRQ_STAT=0x0004, irq=1. W1C 0x0004 -> irq=0. W1C coincident with a new edge on bit 2 -> IRQ_STAT stays 0x0004.
- Read unmapped 0x40 -> r_data=0, ack=1. Write with gpsl_sel_i=0 -> no ack, no state change. Hold req 4 cycles -> ack pattern 0,1,0,1.
- Build without GPSL_DEBOUNCE_EN -> switch change is visible in SW_DATA 3 cycles later; DB_LIMIT reads 0.
